// File: rtl/store_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module  : store_checker_pkg
// Brief   : Shared types and width helpers for the store checker.
// Revision: 1.0 - initial release
// ============================================================================
package store_checker_pkg;

    // Table fields are sized for the widest supported XLEN; narrower builds zero-extend.
    localparam int MAX_XLEN = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    typedef struct packed {
        logic [MAX_XLEN-1:0] adr;
        logic [MAX_XLEN-1:0] data;
    } entry_t;

    // Index width, never below one bit so a single-entry table still has a port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sc_timer.sv
`default_nettype none
// ============================================================================
// Module  : sc_timer
// Brief   : Up-counter with synchronous clear and terminal-count flag.
// Revision: 1.0 - initial release
// ============================================================================
module sc_timer #(
    parameter int WIDTH    = 32,
    parameter int TERMINAL = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == WIDTH'(TERMINAL - 1));

endmodule
`default_nettype wire

// File: rtl/store_checker.sv
`default_nettype none
// ============================================================================
// Module  : store_checker
// Brief   : Compares core stores against a table of expected (addr,data) pairs
//           and reports pass / fail / timeout. Define STORE_CHECKER_UNORDERED_EN
//           to accept the expected stores in any order.
// Revision: 1.0 - initial release
// ============================================================================
module store_checker
    import store_checker_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NUM_CHECKS     = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int IGN_LO         = 96,
    parameter int IGN_HI         = 96
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           MemWrite,
    input  logic [XLEN-1:0]                DataAdr,
    input  logic [XLEN-1:0]                WriteData,
    input  logic                           start,
    input  logic                           cfg_we,
    input  logic [idx_w(NUM_CHECKS)-1:0]   cfg_idx,
    input  logic [XLEN-1:0]                cfg_adr,
    input  logic [XLEN-1:0]                cfg_data,
    output logic                           done,
    output logic                           pass,
    output logic                           fail,
    output logic                           timeout,
    output logic [XLEN-1:0]                fail_adr,
    output logic [XLEN-1:0]                fail_data,
    output logic [idx_w(NUM_CHECKS)-1:0]   fail_idx,
    output logic [cnt_w(NUM_CHECKS)-1:0]   match_count,
    output logic [XLEN-1:0]                write_count
);

    localparam int IDX_W = idx_w(NUM_CHECKS);
    localparam int CNT_W = cnt_w(NUM_CHECKS);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [XLEN-1:0] IGN_LO_A = XLEN'(IGN_LO);
    localparam logic [XLEN-1:0] IGN_HI_A = XLEN'(IGN_HI);

    state_e           state_q, state_d;
    entry_t           table_q [DEPTH];
    entry_t           table_d [DEPTH];
    logic [CNT_W-1:0] match_count_q, match_count_d;
    logic [XLEN-1:0]  write_count_q, write_count_d;
    logic [XLEN-1:0]  fail_adr_q, fail_adr_d;
    logic [XLEN-1:0]  fail_data_q, fail_data_d;
    logic [IDX_W-1:0] fail_idx_q, fail_idx_d;

    entry_t           store_e;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] exp_idx;
    logic             in_window;
    logic             cfg_ok;
    logic             timer_clear;
    logic             timer_tc;

    assign store_e   = '{adr: MAX_XLEN'(DataAdr), data: MAX_XLEN'(WriteData)};
    assign in_window = (DataAdr >= IGN_LO_A) && (DataAdr <= IGN_HI_A);

    generate
        if (DEPTH == NUM_CHECKS) begin : g_idx_full
            assign cfg_ok = 1'b1;
        end else begin : g_idx_partial
            assign cfg_ok = (cfg_idx < IDX_W'(NUM_CHECKS));
        end
    endgenerate

`ifdef STORE_CHECKER_UNORDERED_EN
    logic [DEPTH-1:0] matched_q, matched_d;

    // Downward scans leave the lowest qualifying index in hit_idx / exp_idx.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        exp_idx = '0;
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            if (!matched_q[i]) begin
                exp_idx = IDX_W'(i);
                if (table_q[i] == store_e) begin
                    hit     = 1'b1;
                    hit_idx = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        matched_d = matched_q;
        if (state_q != ST_ARMED) begin
            if (start) begin
                matched_d = '0;
            end
        end else if (MemWrite && hit) begin
            matched_d[hit_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            matched_q <= '0;
        end else begin
            matched_q <= matched_d;
        end
    end
`else
    always_comb begin
        exp_idx = IDX_W'(match_count_q);
        hit_idx = exp_idx;
        hit     = (table_q[exp_idx] == store_e);
    end
`endif

    always_comb begin
        state_d       = state_q;
        table_d       = table_q;
        match_count_d = match_count_q;
        write_count_d = write_count_q;
        fail_adr_d    = fail_adr_q;
        fail_data_d   = fail_data_q;
        fail_idx_d    = fail_idx_q;
        timer_clear   = 1'b0;

        case (state_q)
            ST_ARMED: begin
                if (MemWrite) begin
                    write_count_d = write_count_q + XLEN'(1);
                    if (hit) begin
                        match_count_d = match_count_q + CNT_W'(1);
                        if (match_count_q == CNT_W'(NUM_CHECKS - 1)) begin
                            state_d = ST_PASS;
                        end
                    end else if (!in_window) begin
                        state_d     = ST_FAIL;
                        fail_adr_d  = DataAdr;
                        fail_data_d = WriteData;
                        fail_idx_d  = exp_idx;
                    end
                end
                // A store that decides the outcome this cycle beats the timeout.
                if ((state_d == ST_ARMED) && timer_tc) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: begin
                if (cfg_we && cfg_ok) begin
                    table_d[cfg_idx] = '{adr: MAX_XLEN'(cfg_adr), data: MAX_XLEN'(cfg_data)};
                end
                if (start) begin
                    state_d       = ST_ARMED;
                    match_count_d = '0;
                    write_count_d = '0;
                    fail_adr_d    = '0;
                    fail_data_d   = '0;
                    fail_idx_d    = '0;
                    timer_clear   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            match_count_q <= '0;
            write_count_q <= '0;
            fail_adr_q    <= '0;
            fail_data_q   <= '0;
            fail_idx_q    <= '0;
        end else begin
            state_q       <= state_d;
            match_count_q <= match_count_d;
            write_count_q <= write_count_d;
            fail_adr_q    <= fail_adr_d;
            fail_data_q   <= fail_data_d;
            fail_idx_q    <= fail_idx_d;
        end
    end

    // Expected table survives reset so a run can be repeated without reloading.
    always_ff @(posedge clk) begin
        table_q <= table_d;
    end

    sc_timer #(
        .WIDTH    (XLEN),
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (state_q == ST_ARMED),
        .tc     (timer_tc)
    );

    assign pass        = (state_q == ST_PASS);
    assign fail        = (state_q == ST_FAIL);
    assign timeout     = (state_q == ST_TIMEOUT);
    assign done        = pass | fail | timeout;
    assign fail_adr    = fail_adr_q;
    assign fail_data   = fail_data_q;
    assign fail_idx    = fail_idx_q;
    assign match_count = match_count_q;
    assign write_count = write_count_q;

endmodule
`default_nettype wire

// File: tb/tb_store_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_store_checker
// Brief   : Directed self-checking bench; instance A has one table entry,
//           instance B two entries, both with a 20-cycle timeout.
// Revision: 1.0 - initial release
// ============================================================================
module tb_store_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr, WriteData, cfg_adr, cfg_data;
    logic        start_a, start_b, cfg_we_a, cfg_we_b;
    logic        cfg_idx_a, cfg_idx_b;

    logic        done_a, pass_a, fail_a, timeout_a;
    logic [31:0] fail_adr_a, fail_data_a, write_count_a;
    logic        fail_idx_a;
    logic        match_count_a;

    logic        done_b, pass_b, fail_b, timeout_b;
    logic [31:0] fail_adr_b, fail_data_b, write_count_b;
    logic        fail_idx_b;
    logic [1:0]  match_count_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    store_checker #(.XLEN(32), .NUM_CHECKS(1), .TIMEOUT_CYCLES(20)) dut_a (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .start(start_a), .cfg_we(cfg_we_a), .cfg_idx(cfg_idx_a),
        .cfg_adr(cfg_adr), .cfg_data(cfg_data), .done(done_a), .pass(pass_a),
        .fail(fail_a), .timeout(timeout_a), .fail_adr(fail_adr_a), .fail_data(fail_data_a),
        .fail_idx(fail_idx_a), .match_count(match_count_a), .write_count(write_count_a)
    );

    store_checker #(.XLEN(32), .NUM_CHECKS(2), .TIMEOUT_CYCLES(20)) dut_b (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .start(start_b), .cfg_we(cfg_we_b), .cfg_idx(cfg_idx_b),
        .cfg_adr(cfg_adr), .cfg_data(cfg_data), .done(done_b), .pass(pass_b),
        .fail(fail_b), .timeout(timeout_b), .fail_adr(fail_adr_b), .fail_data(fail_data_b),
        .fail_idx(fail_idx_b), .match_count(match_count_b), .write_count(write_count_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic cfg_a(input logic idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we_a = 1'b1; cfg_idx_a = idx; cfg_adr = a; cfg_data = d;
        tick();
        cfg_we_a = 1'b0;
    endtask

    task automatic cfg_b(input logic idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we_b = 1'b1; cfg_idx_b = idx; cfg_adr = a; cfg_data = d;
        tick();
        cfg_we_b = 1'b0;
    endtask

    task automatic go_a();
        start_a = 1'b1; tick(); start_a = 1'b0;
    endtask

    task automatic go_b();
        start_b = 1'b1; tick(); start_b = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done_b); end
        checks++; if (match_count_b !== 2'd0) begin errors++; $display("FAIL reset_match: got %0d want 0", match_count_b); end
        checks++; if (write_count_b !== 32'd0) begin errors++; $display("FAIL reset_wcnt: got %0d want 0", write_count_b); end
        checks++; if (fail_adr_b !== 32'd0) begin errors++; $display("FAIL reset_fadr: got %0d want 0", fail_adr_b); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done_a: got %0b want 0", done_a); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_idle_ignore();
        cfg_b(1'b0, 32'd100, 32'd7);
        cfg_b(1'b1, 32'd104, 32'd9);
        do_store(32'd100, 32'd7);
        checks++; if (write_count_b !== 32'd0) begin errors++; $display("FAIL idle_wcnt: got %0d want 0", write_count_b); end
        checks++; if (match_count_b !== 2'd0) begin errors++; $display("FAIL idle_match: got %0d want 0", match_count_b); end
    endtask

    task automatic test_single_pass();
        cfg_a(1'b0, 32'd100, 32'd7);
        go_a();
        do_store(32'd96, 32'd3);
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL single_ign_done: got %0b want 0", done_a); end
        checks++; if (write_count_a !== 32'd1) begin errors++; $display("FAIL single_ign_wcnt: got %0d want 1", write_count_a); end
        do_store(32'd100, 32'd7);
        checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL single_pass: got %0b want 1", pass_a); end
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL single_done: got %0b want 1", done_a); end
        checks++; if (fail_a !== 1'b0) begin errors++; $display("FAIL single_fail: got %0b want 0", fail_a); end
        checks++; if (write_count_a !== 32'd2) begin errors++; $display("FAIL single_wcnt: got %0d want 2", write_count_a); end
        checks++; if (match_count_a !== 1'b1) begin errors++; $display("FAIL single_match: got %0d want 1", match_count_a); end
        do_store(32'd5, 32'd5);
        checks++; if (write_count_a !== 32'd2) begin errors++; $display("FAIL term_wcnt: got %0d want 2", write_count_a); end
        checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL term_sticky: got %0b want 1", pass_a); end
    endtask

    task automatic test_order();
        go_b();
        do_store(32'd104, 32'd9);
`ifdef STORE_CHECKER_UNORDERED_EN
        checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL unord_done: got %0b want 0", done_b); end
        do_store(32'd100, 32'd7);
        checks++; if (pass_b !== 1'b1) begin errors++; $display("FAIL unord_pass: got %0b want 1", pass_b); end
        checks++; if (match_count_b !== 2'd2) begin errors++; $display("FAIL unord_match: got %0d want 2", match_count_b); end
`else
        checks++; if (fail_b !== 1'b1) begin errors++; $display("FAIL order_fail: got %0b want 1", fail_b); end
        checks++; if (pass_b !== 1'b0) begin errors++; $display("FAIL order_pass: got %0b want 0", pass_b); end
        checks++; if (fail_adr_b !== 32'd104) begin errors++; $display("FAIL order_fadr: got %0d want 104", fail_adr_b); end
        checks++; if (fail_data_b !== 32'd9) begin errors++; $display("FAIL order_fdata: got %0d want 9", fail_data_b); end
        checks++; if (fail_idx_b !== 1'b0) begin errors++; $display("FAIL order_fidx: got %0d want 0", fail_idx_b); end
`endif
    endtask

    task automatic test_fail_second();
        go_b();
        checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL restart_done: got %0b want 0", done_b); end
        checks++; if (match_count_b !== 2'd0) begin errors++; $display("FAIL restart_match: got %0d want 0", match_count_b); end
        do_store(32'd100, 32'd7);
        checks++; if (match_count_b !== 2'd1) begin errors++; $display("FAIL second_match: got %0d want 1", match_count_b); end
        do_store(32'd200, 32'd1);
        checks++; if (fail_b !== 1'b1) begin errors++; $display("FAIL second_fail: got %0b want 1", fail_b); end
        checks++; if (fail_idx_b !== 1'b1) begin errors++; $display("FAIL second_fidx: got %0d want 1", fail_idx_b); end
        checks++; if (fail_adr_b !== 32'd200) begin errors++; $display("FAIL second_fadr: got %0d want 200", fail_adr_b); end
    endtask

    task automatic test_timeout();
        go_b();
        repeat (19) tick();
        checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL to_early_done: got %0b want 0", done_b); end
        tick();
        checks++; if (timeout_b !== 1'b1) begin errors++; $display("FAIL to_flag: got %0b want 1", timeout_b); end
        checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL to_done: got %0b want 1", done_b); end
        checks++; if (pass_b !== 1'b0) begin errors++; $display("FAIL to_pass: got %0b want 0", pass_b); end
    endtask

    task automatic test_deadline_pass();
        go_b();
        do_store(32'd100, 32'd7);
        repeat (18) tick();
        do_store(32'd104, 32'd9);
        checks++; if (pass_b !== 1'b1) begin errors++; $display("FAIL deadline_pass: got %0b want 1", pass_b); end
        checks++; if (timeout_b !== 1'b0) begin errors++; $display("FAIL deadline_to: got %0b want 0", timeout_b); end
        tick();
        checks++; if (timeout_b !== 1'b0) begin errors++; $display("FAIL deadline_to_later: got %0b want 0", timeout_b); end
    endtask

    task automatic test_armed_locked();
        go_b();
        do_store(32'd100, 32'd7);
        cfg_b(1'b1, 32'd300, 32'd1);
        go_b();
        checks++; if (match_count_b !== 2'd1) begin errors++; $display("FAIL locked_start: got %0d want 1", match_count_b); end
        do_store(32'd104, 32'd9);
        checks++; if (pass_b !== 1'b1) begin errors++; $display("FAIL locked_cfg: got %0b want 1", pass_b); end
    endtask

    task automatic test_reset_mid_armed();
        go_b();
        do_store(32'd100, 32'd7);
        checks++; if (match_count_b !== 2'd1) begin errors++; $display("FAIL mid_pre_match: got %0d want 1", match_count_b); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (match_count_b !== 2'd0) begin errors++; $display("FAIL mid_async_match: got %0d want 0", match_count_b); end
        checks++; if (write_count_b !== 32'd0) begin errors++; $display("FAIL mid_async_wcnt: got %0d want 0", write_count_b); end
        checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL mid_async_done: got %0b want 0", done_b); end
        tick();
        reset = 1'b1;
        tick();
        go_b();
        do_store(32'd100, 32'd7);
        do_store(32'd104, 32'd9);
        checks++; if (pass_b !== 1'b1) begin errors++; $display("FAIL mid_retained: got %0b want 1", pass_b); end
        checks++; if (match_count_b !== 2'd2) begin errors++; $display("FAIL mid_retained_match: got %0d want 2", match_count_b); end
    endtask

    task automatic test_window_priority();
        cfg_a(1'b0, 32'd96, 32'd5);
        go_a();
        do_store(32'd96, 32'd4);
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL win_ignore: got %0b want 0", done_a); end
        do_store(32'd96, 32'd5);
        checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL win_priority: got %0b want 1", pass_a); end
    endtask

    initial begin
        reset = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
        cfg_adr = '0; cfg_data = '0; start_a = 1'b0; start_b = 1'b0;
        cfg_we_a = 1'b0; cfg_we_b = 1'b0; cfg_idx_a = 1'b0; cfg_idx_b = 1'b0;
        test_reset();
        test_idle_ignore();
        test_single_pass();
        test_order();
        test_fail_second();
        test_timeout();
        test_deadline_pass();
        test_armed_locked();
        test_reset_mid_armed();
        test_window_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
